// File: rtl/vga_fetch_arbiter.sv
// rtl/vga_fetch_arbiter.sv - frame-buffer SRAM fetch arbiter feeding a show-ahead VGA pixel FIFO
//
// Purpose:
//   Shares one single-port frame-buffer SRAM between the VGA pixel prefetch
//   path and a single write client. Reads walk the frame linearly from word 0
//   and land in a small show-ahead FIFO whose head drives the VGA colour
//   inputs. The prefetch path wins whenever the FIFO plus reads in flight
//   drops below LOW_WATER. Otherwise a pending write goes first, and spare
//   cycles top the FIFO up.
//
// Ports:
//   Clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   frame_start  in   one-cycle pulse, restarts the frame fetch
//   pix_pop      in   VGA consumes the head pixel this cycle
//   pix_data     out  FIFO head pixel (zero while empty)
//   pix_valid    out  FIFO non-empty
//   underflow    out  sticky, a pop arrived while the FIFO was empty
//   wr_req       in   write client request, held until granted
//   wr_addr      in   write word address, stable while wr_req is high
//   wr_data      in   write data, stable while wr_req is high
//   wr_gnt       out  one-cycle pulse, the write is taken at the coming edge
//   sram_addr    out  registered SRAM word address
//   sram_wdata   out  registered SRAM write data
//   sram_we_n    out  registered SRAM write enable, active-low
//   sram_rdata   in   SRAM read data, valid RD_LAT edges after the address edge

module vga_fetch_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int LOW_WATER    = 4,
  parameter int RD_LAT       = 2,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we_n,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One extra bit so the count (and occupancy) can represent a full FIFO.
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LOW_C     = CNT_W'(LOW_WATER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_URGENT,
    ARB_WRITE,
    ARB_READ
  } arb_t;

  // Pixel FIFO storage and pointers.
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr_fifo;
  logic [CNT_W-1:0]  r_count;

  // Bit i is set when the read issued i+1 edges ago is still on its way back.
  logic [RD_LAT-1:0] r_inflight;

  // Frame read pointer and end-of-frame flag.
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_frame_done;

  logic              r_underflow;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_sram_we_n;

  logic [CNT_W-1:0]  w_inflight_cnt;
  logic [CNT_W-1:0]  w_occ;
  logic              w_can_read;
  logic              w_read_ok;
  arb_t              w_arb;
  logic              w_issue_rd;
  logic              w_issue_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;

  // Occupancy counts reads already committed to the FIFO, so the FIFO can
  // never be asked to take a return it has no room for.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + CNT_W'(r_inflight[i]);
    end
  end

  assign w_occ        = r_count + w_inflight_cnt;
  assign w_fifo_empty = (r_count == '0);
  assign w_can_read   = !r_frame_done && (w_occ < DEPTH_C);
  // A restart cycle never reads: the pointer is being rewound at that edge.
  assign w_read_ok    = w_can_read && !frame_start;

  always_comb begin
    w_arb = ARB_IDLE;
    if (!reset) begin
      if (w_read_ok && (w_occ < LOW_C)) begin
        w_arb = ARB_URGENT;
      end else if (wr_req) begin
        w_arb = ARB_WRITE;
      end else if (w_read_ok) begin
        w_arb = ARB_READ;
      end
    end
  end

  assign w_issue_rd = (w_arb == ARB_URGENT) || (w_arb == ARB_READ);
  assign w_issue_wr = (w_arb == ARB_WRITE);
  assign wr_gnt     = w_issue_wr;

  // A return emerging in a restart cycle belongs to the old frame; drop it.
  assign w_push = !reset && !frame_start && r_inflight[RD_LAT-1];
  assign w_pop  = !reset && !frame_start && pix_pop && !w_fifo_empty;

  // SRAM pins. Idle cycles hold the address and deassert the write enable.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_we_n  <= 1'b1;
    end else begin
      r_sram_we_n <= !w_issue_wr;
      if (w_issue_rd) begin
        r_sram_addr <= r_rd_ptr;
      end else if (w_issue_wr) begin
        r_sram_addr  <= wr_addr;
        r_sram_wdata <= wr_data;
      end
    end
  end

  // Frame read pointer. The flag freezes reads once the last word is issued.
  always_ff @(posedge Clock) begin
    if (reset || frame_start) begin
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
    end else if (w_issue_rd) begin
      r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (r_rd_ptr == LAST_ADDR) begin
        r_frame_done <= 1'b1;
      end
    end
  end

  // In-flight pipeline, aligned so the top bit marks the edge the data arrives.
  always_ff @(posedge Clock) begin
    if (reset || frame_start) begin
      r_inflight <= '0;
    end else begin
      r_inflight[0] <= w_issue_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sram_rdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (reset || frame_start) begin
      r_wr_ptr      <= '0;
      r_rd_ptr_fifo <= '0;
      r_count       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr_fifo <= r_rd_ptr_fifo + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset || frame_start) begin
      r_underflow <= 1'b0;
    end else if (pix_pop && w_fifo_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign pix_valid  = !w_fifo_empty;
  // Gate the head so an empty FIFO shows zero rather than stale storage.
  assign pix_data   = w_fifo_empty ? '0 : r_mem[r_rd_ptr_fifo];
  assign underflow  = r_underflow;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we_n  = r_sram_we_n;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// tb/tb_vga_fetch_arbiter.sv - directed-vector bench for vga_fetch_arbiter

module tb_vga_fetch_arbiter;

  logic        Clock = 1'b0;
  logic        reset;

  logic        frame_start, pix_pop, wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pix_data, sram_wdata, sram_rdata;
  logic        pix_valid, underflow, wr_gnt, sram_we_n;
  logic [18:0] sram_addr;

  logic        b_frame_start, b_pix_pop, b_wr_req;
  logic [18:0] b_wr_addr;
  logic [15:0] b_wr_data;
  logic [15:0] b_pix_data, b_sram_wdata, b_sram_rdata;
  logic        b_pix_valid, b_underflow, b_wr_gnt, b_sram_we_n;
  logic [18:0] b_sram_addr;

  int n_vec  = 0;
  int n_miss = 0;
  int gnt_cnt = 0;
  int we_lo_cnt = 0;

  always #5 Clock = ~Clock;

  vga_fetch_arbiter dut (
    .Clock(Clock), .reset(reset), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
    .sram_rdata(sram_rdata)
  );

  vga_fetch_arbiter #(.FRAME_PIXELS(16)) dut16 (
    .Clock(Clock), .reset(reset), .frame_start(b_frame_start), .pix_pop(b_pix_pop),
    .pix_data(b_pix_data), .pix_valid(b_pix_valid), .underflow(b_underflow),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_gnt(b_wr_gnt),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_we_n(b_sram_we_n),
    .sram_rdata(b_sram_rdata)
  );

  // SRAM returns the low address bits; data is captured RD_LAT=2 edges after the address edge.
  always @(posedge Clock) begin
    sram_rdata   <= sram_addr[15:0];
    b_sram_rdata <= b_sram_addr[15:0];
  end

  always @(negedge Clock) begin
    if (wr_gnt) gnt_cnt++;
    if (!sram_we_n) we_lo_cnt++;
  end

  a_no_full_push: assert property (@(posedge Clock) disable iff (reset)
    !(dut.w_push && (dut.r_count == 4'd8)));
  a_no_full_push16: assert property (@(posedge Clock) disable iff (reset)
    !(dut16.w_push && (dut16.r_count == 4'd8)));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Holds wr_req until the grant is seen; returns at +1 after the grant edge.
  task automatic do_write(input logic [18:0] a, input logic [15:0] d, output int wait_cyc);
    wr_addr  = a;
    wr_data  = d;
    wr_req   = 1'b1;
    wait_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (wr_gnt) begin
        wait_cyc = k;
        @(posedge Clock);
        #1;
        break;
      end
      @(posedge Clock);
      #1;
    end
    wr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wc, lat, n, g0, w0;
    logic found;

    reset = 1'b1;
    frame_start = 1'b0; pix_pop = 1'b0;
    wr_req = 1'b1; wr_addr = 19'h155; wr_data = 16'h5A5A;
    b_frame_start = 1'b0; b_pix_pop = 1'b0; b_wr_req = 1'b0;
    b_wr_addr = '0; b_wr_data = '0;
    cyc(3);

    chk("rst_we_n", sram_we_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_gnt", wr_gnt, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_valid16", b_pix_valid, 0);

    // Prefill: frame_start sampled at the first edge out of reset.
    wr_req = 1'b0;
    reset = 1'b0;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("pf_addr", sram_addr, k);
      if (k == 1) chk("pf_valid_lo", pix_valid, 0);
      if (k == 2) chk("pf_valid_hi", pix_valid, 1);
    end
    cyc(4);
    chk("pf_stop_addr", sram_addr, 7);
    chk("pf_we_n", sram_we_n, 1);
    chk("pf_head", pix_data, 0);

    // Steady stream of 640 pops.
    pix_pop = 1'b1;
    for (int i = 0; i < 640; i++) begin
      chk("stream", {pix_valid, pix_data}, {1'b1, 16'(i)});
      cyc();
    end
    pix_pop = 1'b0;
    chk("stream_uf", underflow, 0);

    cyc(6);
    chk("refill_head", pix_data, 640);
    chk("refill_addr", sram_addr, 647);

    // Write while the FIFO is full: granted at once, one strobe.
    g0 = gnt_cnt; w0 = we_lo_cnt;
    do_write(19'h100, 16'hABCD, wc);
    chk("wc_wait", wc, 0);
    chk("wc_we_lo", sram_we_n, 0);
    chk("wc_addr", sram_addr, 19'h100);
    chk("wc_wdata", sram_wdata, 16'hABCD);
    cyc();
    chk("wc_we_hi", sram_we_n, 1);
    cyc(3);
    chk("wc_gnt_pulses", gnt_cnt - g0, 1);
    chk("wc_we_cycles", we_lo_cnt - w0, 1);
    chk("wc_head", pix_data, 640);

    // Write against an empty FIFO: four urgent reads go first.
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    do_write(19'h200, 16'h1234, wc);
    chk("lw_wait", wc, 4);
    chk("lw_we_lo", sram_we_n, 0);
    chk("lw_addr", sram_addr, 19'h200);

    // Underflow set, sticky, and cleared by frame_start even with a pop.
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    pix_pop = 1'b1;
    cyc();
    pix_pop = 1'b0;
    chk("uf_set", underflow, 1);
    cyc(10);
    chk("uf_sticky", underflow, 1);
    chk("uf_head", pix_data, 0);
    frame_start = 1'b1;
    pix_pop = 1'b1;
    cyc();
    chk("uf_clr", underflow, 0);
    cyc();
    chk("fs_wins_uf", underflow, 0);
    chk("fs_wins_valid", pix_valid, 0);
    frame_start = 1'b0;
    pix_pop = 1'b0;

    // Restart one cycle after the read of address 37 is issued.
    cyc(4);
    pix_pop = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (sram_we_n && (sram_addr == 19'd37)) begin
        found = 1'b1;
        frame_start = 1'b1;
        break;
      end
    end
    chk("rs_found37", found, 1);
    cyc();
    frame_start = 1'b0;
    pix_pop = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (pix_valid) begin
        lat = k;
        break;
      end
      cyc();
    end
    chk("rs_lat", lat, 3);
    chk("rs_first", pix_data, 0);
    chk("rs_uf", underflow, 0);

    // End of frame on the 16-word build.
    b_frame_start = 1'b1;
    cyc();
    b_frame_start = 1'b0;
    b_pix_pop = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (b_pix_valid) begin
        chk("eof_seq", b_pix_data, n);
        n++;
        if (n == 16) break;
      end
      cyc();
    end
    chk("eof_count", n, 16);
    cyc();
    chk("eof_valid_fall", b_pix_valid, 0);
    cyc(20);
    chk("eof_last_addr", b_sram_addr, 15);
    chk("eof_valid_stay", b_pix_valid, 0);
    b_pix_pop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
